// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for one shared, two-stage registered FP32 adder.
// Also holds the combinational adder and its registered wrapper that sit behind the arbiter.

module fp_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic        overflow_o,
    output logic        underflow_o
);
    logic              sa, sb, s_big, s_sml;
    logic [7:0]        ea, eb, e_big, e_sml, shamt;
    logic [23:0]       ma, mb, m_big, m_sml;
    logic [26:0]       big_x, sml_x, sml_ext;
    logic [27:0]       raw;
    logic [4:0]        lz;
    logic              lz_found;
    logic [26:0]       norm;
    logic signed [9:0] exp_n, exp_r;
    logic [24:0]       mant_r;
    logic [23:0]       mant;
    logic              rnd_up;
    logic              a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        // NOTE: every variable is given a default before any branch so no latch is inferred.
        sum_o       = 32'h0;
        overflow_o  = 1'b0;
        underflow_o = 1'b0;
        lz          = 5'd0;
        lz_found    = 1'b0;

        // Subnormal inputs are flushed to zero; exponent 255 takes the special path below.
        sa = a_i[31];
        sb = b_i[31];
        ea = a_i[30:23];
        eb = b_i[30:23];
        ma = (ea != 8'd0) ? {1'b1, a_i[22:0]} : 24'h0;
        mb = (eb != 8'd0) ? {1'b1, b_i[22:0]} : 24'h0;
        a_nan = (ea == 8'hFF) && (a_i[22:0] != 23'h0);
        b_nan = (eb == 8'hFF) && (b_i[22:0] != 23'h0);
        a_inf = (ea == 8'hFF) && (a_i[22:0] == 23'h0);
        b_inf = (eb == 8'hFF) && (b_i[22:0] == 23'h0);

        if ({ea, ma} >= {eb, mb}) begin
            s_big = sa; e_big = ea; m_big = ma;
            s_sml = sb; e_sml = eb; m_sml = mb;
        end else begin
            s_big = sb; e_big = eb; m_big = mb;
            s_sml = sa; e_sml = ea; m_sml = ma;
        end

        // Three extra LSBs carry guard, round and sticky through alignment.
        shamt   = e_big - e_sml;
        big_x   = {m_big, 3'b000};
        sml_ext = {m_sml, 3'b000};
        if (shamt >= 8'd27) begin
            sml_x = {26'h0, |m_sml};
        end else begin
            sml_x    = sml_ext >> shamt;
            sml_x[0] = sml_x[0] | (|(sml_ext & ((27'd1 << shamt) - 27'd1)));
        end

        if (s_big == s_sml) raw = {1'b0, big_x} + {1'b0, sml_x};
        else                raw = {1'b0, big_x} - {1'b0, sml_x};

        for (int i = 26; i >= 0; i--) begin
            if (!lz_found && raw[i]) begin
                lz       = 5'(26 - i);
                lz_found = 1'b1;
            end
        end

        if (raw[27]) begin
            norm  = raw[27:1] | {26'h0, raw[0]};
            exp_n = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            norm  = raw[26:0] << lz;
            exp_n = $signed({2'b00, e_big}) - $signed({5'b00000, lz});
        end

        // Round to nearest, ties to even; a carry out renormalises by one place.
        rnd_up = norm[2] && (norm[1] || norm[0] || norm[3]);
        mant_r = {1'b0, norm[26:3]} + {24'h0, rnd_up};
        if (mant_r[24]) begin
            mant  = mant_r[24:1];
            exp_r = exp_n + 10'sd1;
        end else begin
            mant  = mant_r[23:0];
            exp_r = exp_n;
        end

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            sum_o = 32'h7FC00000;
        end else if (a_inf) begin
            sum_o = a_i;
        end else if (b_inf) begin
            sum_o = b_i;
        end else if (raw == 28'h0) begin
            sum_o = 32'h0;
        end else if (exp_r >= 10'sd255) begin
            sum_o      = {s_big, 8'hFF, 23'h0};
            overflow_o = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            sum_o       = {s_big, 31'h0};
            underflow_o = 1'b1;
        end else begin
            sum_o = {s_big, exp_r[7:0], mant[22:0]};
        end
    end
endmodule

// Registered adder: operand registers, combinational add, result registers, one common enable.
module fp_adder_buff (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic        overflow_o,
    output logic        underflow_o
);
    logic [31:0] a_q, b_q, sum_d, sum_q;
    logic        ovf_d, ovf_q, unf_d, unf_q;

    fp_adder u_add (
        .a_i         (a_q),
        .b_i         (b_q),
        .sum_o       (sum_d),
        .overflow_o  (ovf_d),
        .underflow_o (unf_d)
    );

    // NOTE: reset is synchronous and overrides en, so the stages clear even while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= 32'h0;
            b_q   <= 32'h0;
            sum_q <= 32'h0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (en) begin
            a_q   <= a_i;
            b_q   <= b_i;
            sum_q <= sum_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign sum_o       = sum_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
endmodule

module fp_add_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_sum,
    output logic        rsp_overflow,
    output logic        rsp_underflow,
    output logic        add_en,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    input  logic        add_overflow,
    input  logic        add_underflow,
    output logic        busy
);
    // v_q/t_q shadow the adder stages: bit 0 is the operand register, bit LAT-1 the result register.
    logic [LAT-1:0] v_q, v_d, t_q, t_d;
    logic           prio_q, prio_d;
    logic           head_valid, head_tag, head_ready, stall;
    logic           grant_any, grant_id;

    always_comb begin
        head_valid = v_q[LAT-1];
        head_tag   = t_q[LAT-1];
        head_ready = head_tag ? rsp1_ready : rsp0_ready;
        // Reset overrides a stalled head so the adder always sees en=1 and clears.
        stall      = head_valid && !head_ready && !rst;

        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (!stall) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = prio_q;
            end else if (req0_valid) begin
                grant_any = 1'b1;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end

        v_d    = v_q;
        t_d    = t_q;
        prio_d = prio_q;
        if (!stall) begin
            v_d = {v_q[LAT-2:0], grant_any};
            t_d = {t_q[LAT-2:0], grant_id};
            if (grant_any) prio_d = ~grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            t_q    <= '0;
            prio_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            t_q    <= t_d;
            prio_q <= prio_d;
        end
    end

    assign req0_ready    = !stall && !rst && grant_any && !grant_id;
    assign req1_ready    = !stall && !rst && grant_any &&  grant_id;
    assign add_en        = !stall;
    assign add_a         = !grant_any ? 32'h0 : (grant_id ? req1_a : req0_a);
    assign add_b         = !grant_any ? 32'h0 : (grant_id ? req1_b : req0_b);
    assign rsp0_valid    = head_valid && !head_tag;
    assign rsp1_valid    = head_valid &&  head_tag;
    assign rsp_sum       = add_sum;
    assign rsp_overflow  = add_overflow;
    assign rsp_underflow = add_underflow;
    assign busy          = |v_q;
endmodule
